m72_pic_nest: RTL and testbench

Parametrised interrupt controller for the M72 family CPU cores. It accepts NUM_IRQ request lines and selects each input as edge- or level-triggered. Requests are latched in a request register (IRR). Nesting is fully tracked through an in-service register (ISR), so a request is only raised when it outranks everything currently in service. The block sits between the board's interrupt sources and the V30 core's int_req/int_ack handshake.

---
 rtl/m72_pic_nest_if.sv | 25 ++
 rtl/m72_pic_nest.sv | 160 ++++++++++++++++
 tb/tb_m72_pic_nest.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m72_pic_nest_if.sv
// Register bus and CPU interrupt handshake for m72_pic_nest.
// master = CPU/bus side, slave = controller side.
interface m72_pic_nest_if #(
    parameter int VEC_W = 9
);
    logic             cs;
    logic             wr;
    logic             rd;
    logic [1:0]       addr;
    logic [15:0]      din;
    logic [15:0]      dout;
    logic             int_req;
    logic [VEC_W-1:0] int_vector;
    logic             int_ack;

    modport master (
        output cs, wr, rd, addr, din, int_ack,
        input  dout, int_req, int_vector
    );

    modport slave (
        input  cs, wr, rd, addr, din, int_ack,
        output dout, int_req, int_vector
    );
endinterface

// File: rtl/m72_pic_nest.sv
// Nesting interrupt controller: edge/level capture into IRR, in-service
// tracking in ISR, single outstanding int_req/int_ack handshake.
module m72_pic_nest #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    m72_pic_nest_if.slave      bus,
    input  logic [NUM_IRQ-1:0] intp
);

    logic               en_q, en_d;
    logic               aeoi_q, aeoi_d;
    logic [8:0]         vbase_q, vbase_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] intp_d_q;
    logic [3:0]         pend_q, pend_d;
    logic               int_req_q, int_req_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [15:0]        dout_q, dout_d;

    logic        wr_en;
    logic        rd_en;
    logic        ack;
    logic        cand_vld;
    logic [3:0]  cand;
    logic        blocked;
    logic        eoi_hit;
    logic [15:0] vsum;

    always_comb begin
        wr_en   = bus.cs & bus.wr;
        rd_en   = bus.cs & bus.rd;
        ack     = int_req_q & bus.int_ack;
        en_d    = en_q;
        aeoi_d  = aeoi_q;
        vbase_d = vbase_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        dout_d  = dout_q;

        if (wr_en) begin
            unique case (bus.addr)
                2'd0: begin
                    en_d    = bus.din[0];
                    aeoi_d  = bus.din[1];
                    vbase_d = bus.din[15:7];
                end
                2'd1: mask_d = bus.din[NUM_IRQ-1:0];
                2'd2: mode_d = bus.din[NUM_IRQ-1:0];
                default: ;
            endcase
        end

        if (rd_en) begin
            unique case (bus.addr)
                2'd0: dout_d = {vbase_q, 5'd0, aeoi_q, en_q};
                2'd1: dout_d = 16'(mask_q);
                2'd2: dout_d = 16'(irr_q);
                default: dout_d = 16'(isr_q);
            endcase
        end

        // A fresh edge on the acked line wins over the ack clear.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mode_q[i])
                irr_d[i] = intp[i];
            else
                irr_d[i] = (intp[i] & ~intp_d_q[i]) |
                           (irr_q[i] & ~(ack && pend_q == 4'(i)));
        end

        isr_d   = isr_q;
        eoi_hit = 1'b0;
        if (wr_en && bus.addr == 2'd3) begin
            if (bus.din[7]) begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (!eoi_hit && isr_q[i]) begin
                        isr_d[i] = 1'b0;
                        eoi_hit  = 1'b1;
                    end
                end
            end else if (bus.din[6]) begin
                for (int i = 0; i < NUM_IRQ; i++)
                    if (bus.din[3:0] == 4'(i))
                        isr_d[i] = 1'b0;
            end
        end
        if (ack && !aeoi_q) begin
            for (int i = 0; i < NUM_IRQ; i++)
                if (pend_q == 4'(i))
                    isr_d[i] = 1'b1;
        end

        cand_vld = 1'b0;
        cand     = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!cand_vld && irr_q[i] && !mask_q[i]) begin
                cand_vld = 1'b1;
                cand     = 4'(i);
            end
        end
        blocked = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (isr_q[i] && 4'(i) <= cand)
                blocked = 1'b1;

        vsum      = 16'(vbase_q) + {10'd0, cand, 2'b00};
        int_req_d = int_req_q;
        vec_d     = vec_q;
        pend_d    = pend_q;
        if (ack) begin
            int_req_d = 1'b0;
        end else if (!int_req_q && en_q && cand_vld && !blocked) begin
            int_req_d = 1'b1;
            vec_d     = vsum[VEC_W-1:0];
            pend_d    = cand;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            aeoi_q    <= 1'b0;
            vbase_q   <= '0;
            mask_q    <= '1;
            mode_q    <= '0;
            irr_q     <= '0;
            isr_q     <= '0;
            intp_d_q  <= '0;
            pend_q    <= '0;
            int_req_q <= 1'b0;
            vec_q     <= '0;
            dout_q    <= '0;
        end else if (ce) begin
            en_q      <= en_d;
            aeoi_q    <= aeoi_d;
            vbase_q   <= vbase_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            intp_d_q  <= intp;
            pend_q    <= pend_d;
            int_req_q <= int_req_d;
            vec_q     <= vec_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vector = vec_q;
    assign bus.dout       = dout_q;

endmodule

// File: tb/tb_m72_pic_nest.sv
// Directed scenarios plus random traffic for m72_pic_nest, checked
// against a register-level reference model of the controller.
module tb_m72_pic_nest;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic [7:0] intp;

    m72_pic_nest_if #(.VEC_W(9)) bus ();

    m72_pic_nest #(.NUM_IRQ(8), .VEC_W(9)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ce     (ce),
        .bus    (bus),
        .intp   (intp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_ctrl, m_mask, m_mode, m_irr, m_isr;
    int m_prev, m_pend, m_req, m_vec, m_dout;

    function automatic void model_reset();
        m_ctrl = 0; m_mask = 8'hFF; m_mode = 0;
        m_irr  = 0; m_isr  = 0;     m_prev = 0;
        m_pend = 0; m_req  = 0;     m_vec  = 0;
        m_dout = 0;
    endfunction

    task automatic model_step();
        int ack, n_ctrl, n_mask, n_mode, n_irr, n_isr;
        int n_req, n_vec, n_pend, n_dout, rise, cands, c, d, clr;
        if (!ce) return;
        d      = int'(bus.din);
        ack    = (m_req != 0 && bus.int_ack) ? 1 : 0;
        n_ctrl = m_ctrl; n_mask = m_mask; n_mode = m_mode;
        n_isr  = m_isr;  n_dout = m_dout;
        n_req  = m_req;  n_vec  = m_vec;  n_pend = m_pend;
        if (bus.cs && bus.rd) begin
            case (bus.addr)
                2'd0: n_dout = m_ctrl;
                2'd1: n_dout = m_mask;
                2'd2: n_dout = m_irr;
                default: n_dout = m_isr;
            endcase
        end
        if (bus.cs && bus.wr) begin
            case (bus.addr)
                2'd0: n_ctrl = d & 16'hFF83;
                2'd1: n_mask = d & 8'hFF;
                2'd2: n_mode = d & 8'hFF;
                default: begin
                    if (d & 8'h80)
                        n_isr = m_isr & (m_isr - 1);
                    else if ((d & 8'h40) && (d & 15) < 8)
                        n_isr = m_isr & ~(1 << (d & 15));
                end
            endcase
        end
        rise  = int'(intp) & ~m_prev;
        clr   = ack ? (1 << m_pend) : 0;
        n_irr = ((m_mode & int'(intp)) |
                 (~m_mode & (rise | (m_irr & ~clr)))) & 8'hFF;
        if (ack && !(m_ctrl & 2))
            n_isr = n_isr | (1 << m_pend);
        if (ack) begin
            n_req = 0;
        end else if (m_req == 0 && (m_ctrl & 1)) begin
            cands = m_irr & ~m_mask & 8'hFF;
            if (cands != 0) begin
                c = $clog2(cands & -cands);
                if ((m_isr & ((2 << c) - 1)) == 0) begin
                    n_req  = 1;
                    n_vec  = ((m_ctrl >> 7) + 4 * c) % 512;
                    n_pend = c;
                end
            end
        end
        m_ctrl = n_ctrl; m_mask = n_mask; m_mode = n_mode;
        m_irr  = n_irr;  m_isr  = n_isr;  m_prev = int'(intp);
        m_req  = n_req;  m_vec  = n_vec;  m_pend = n_pend;
        m_dout = n_dout;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        chk("int_req", 32'(bus.int_req), m_req);
        chk("int_vector", 32'(bus.int_vector), m_vec);
        chk("dout", 32'(bus.dout), m_dout);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] v);
        bus.cs = 1; bus.wr = 1; bus.addr = a; bus.din = v;
        cyc();
        bus.cs = 0; bus.wr = 0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
        bus.cs = 1; bus.rd = 1; bus.addr = a;
        cyc();
        bus.cs = 0; bus.rd = 0;
        v = bus.dout;
    endtask

    task automatic wait_req(input string tag, input int max);
        int n = 0;
        while (!bus.int_req && n < max) begin
            cyc();
            n++;
        end
        chk(tag, 32'(bus.int_req), 1);
    endtask

    task automatic do_ack();
        bus.int_ack = 1;
        cyc();
        bus.int_ack = 0;
    endtask

    logic [15:0] rv;

    initial begin
        reset_n = 0; ce = 1; intp = 0;
        bus.cs = 0; bus.wr = 0; bus.rd = 0;
        bus.addr = 0; bus.din = 0; bus.int_ack = 0;
        model_reset();
        #12;
        chk("rst_req", 32'(bus.int_req), 0);
        chk("rst_vec", 32'(bus.int_vector), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        @(negedge clk);
        reset_n = 1;

        // Basic edge request on line 3
        wr_reg(2'd0, 16'h0201);
        wr_reg(2'd1, 16'h0000);
        intp = 8'h08;
        cyc();
        chk("t1_req_edge_k", 32'(bus.int_req), 0);
        intp = 8'h00;
        cyc();
        chk("t1_req", 32'(bus.int_req), 1);
        chk("t1_vec", 32'(bus.int_vector), 16);
        do_ack();
        chk("t1_req_drop", 32'(bus.int_req), 0);
        chk("t1_vec_hold", 32'(bus.int_vector), 16);
        rd_reg(2'd3, rv);
        chk("t1_isr", 32'(rv), 32'h0008);
        rd_reg(2'd2, rv);
        chk("t1_irr", 32'(rv), 32'h0000);

        // Nesting: 5 blocked by 3, 1 preempts
        intp = 8'h20; cyc();
        intp = 8'h00; cyc(); cyc();
        chk("t2_blocked", 32'(bus.int_req), 0);
        intp = 8'h02; cyc();
        intp = 8'h00; cyc();
        chk("t2_req", 32'(bus.int_req), 1);
        chk("t2_vec", 32'(bus.int_vector), 8);
        do_ack();
        rd_reg(2'd3, rv);
        chk("t2_isr_nest", 32'(rv), 32'h000A);
        wr_reg(2'd3, 16'h0080);
        rd_reg(2'd3, rv);
        chk("t2_nseoi", 32'(rv), 32'h0008);
        chk("t2_still_blk", 32'(bus.int_req), 0);
        wr_reg(2'd3, 16'h0043);
        cyc();
        chk("t2_req5", 32'(bus.int_req), 1);
        chk("t2_vec5", 32'(bus.int_vector), 24);
        do_ack();
        wr_reg(2'd3, 16'h0080);
        rd_reg(2'd3, rv);
        chk("t2_isr_clr", 32'(rv), 0);

        // Masked edge remembered
        wr_reg(2'd1, 16'h0004);
        intp = 8'h04; cyc();
        intp = 8'h00; cyc(); cyc();
        chk("t3_masked", 32'(bus.int_req), 0);
        rd_reg(2'd2, rv);
        chk("t3_irr", 32'(rv), 32'h0004);
        wr_reg(2'd1, 16'h0000);
        chk("t3_wr_edge", 32'(bus.int_req), 0);
        cyc();
        chk("t3_req", 32'(bus.int_req), 1);
        chk("t3_vec", 32'(bus.int_vector), 12);
        do_ack();
        wr_reg(2'd3, 16'h0080);

        // Level input with auto-EOI
        wr_reg(2'd2, 16'h0001);
        wr_reg(2'd0, 16'h0203);
        intp = 8'h01;
        for (int k = 0; k < 3; k++) begin
            wait_req("t4_req", 4);
            chk("t4_vec", 32'(bus.int_vector), 4);
            do_ack();
            chk("t4_gap", 32'(bus.int_req), 0);
        end
        intp = 8'h00;
        cyc();
        if (bus.int_req) do_ack();
        cyc(); cyc(); cyc();
        chk("t4_stop", 32'(bus.int_req), 0);
        rd_reg(2'd3, rv);
        chk("t4_isr", 32'(rv), 0);

        // Edge coincident with its own ack
        wr_reg(2'd2, 16'h0000);
        wr_reg(2'd0, 16'h0201);
        intp = 8'h40; cyc();
        intp = 8'h00; cyc();
        chk("t5_req", 32'(bus.int_req), 1);
        chk("t5_vec", 32'(bus.int_vector), 28);
        intp = 8'h40;
        do_ack();
        intp = 8'h00;
        chk("t5_ack", 32'(bus.int_req), 0);
        cyc();
        rd_reg(2'd2, rv);
        chk("t5_irr", 32'(rv), 32'h0040);
        rd_reg(2'd3, rv);
        chk("t5_isr", 32'(rv), 32'h0040);
        chk("t5_blk", 32'(bus.int_req), 0);
        wr_reg(2'd3, 16'h0046);
        cyc();
        chk("t5_req2", 32'(bus.int_req), 1);
        chk("t5_vec2", 32'(bus.int_vector), 28);

        // Async reset mid-handshake
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("t6_req_rst", 32'(bus.int_req), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        rd_reg(2'd1, rv);
        chk("t6_mask", 32'(rv), 32'h00FF);
        rd_reg(2'd2, rv);
        chk("t6_irr", 32'(rv), 0);
        rd_reg(2'd3, rv);
        chk("t6_isr", 32'(rv), 0);

        // Random traffic against the model
        wr_reg(2'd0, 16'h0201);
        wr_reg(2'd1, 16'h0000);
        for (int k = 0; k < 800; k++) begin
            ce   = ($urandom_range(0, 3) != 0);
            intp = intp ^ 8'($urandom & $urandom);
            bus.int_ack = $urandom_range(0, 1);
            bus.cs = 0; bus.wr = 0; bus.rd = 0;
            bus.addr = 2'($urandom);
            bus.din  = 16'($urandom);
            case ($urandom_range(0, 9))
                0: begin
                    bus.cs = 1; bus.wr = 1;
                    if (bus.addr == 2'd0)
                        bus.din[0] = ($urandom_range(0, 4) != 0);
                    if (bus.addr == 2'd3 && $urandom_range(0, 1))
                        bus.din[7] = 1;
                end
                1, 2: begin
                    bus.cs = 1; bus.rd = 1;
                end
                default: ;
            endcase
            cyc();
        end
        bus.cs = 0; bus.wr = 0; bus.rd = 0; bus.int_ack = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
